movavg_acc: RTL and testbench
=============================

MOVAVG_ACC -- requirements
Module: movavg_acc

Interface
REQ-001 SHALL have parameter DW, default 16, the signed sample width.
REQ-002 SHALL have parameter RD_LAT, default 3, the clocks from the enable rising edge to valid delayed-sample data on q (range 1..7).
REQ-003 SHALL have parameter SHIFT, default 6, the arithmetic right shift applied to the sum to form dout.
REQ-004 SHALL have port clk, input, 1, the system clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-006 SHALL have port enable, input, 1, the sample strobe shared with the circular-buffer address stage; a new sample is marked by a 0->1 transition.
REQ-007 SHALL have port din, input, DW, the new signed sample, valid on the clock the rising edge is detected.
REQ-008 SHALL have port q, input, DW, the signed delayed sample read from buffer RAM.
REQ-009 SHALL have port window, input, 7, the window length in samples, 0..65.
REQ-010 SHALL have port dout, output, DW, the saturated value sum>>>SHIFT.
REQ-011 SHALL have port dout_valid, output, 1, a one-clock pulse marking a new dout.
REQ-012 SHALL have port sum, output, DW+7, the signed running window sum.
REQ-013 SHALL have port overrun, output, 1, a sticky flag set when a new edge arrives while busy.

Function
REQ-014 SHALL register enable into prev_en; edge = enable & ~prev_en.
REQ-015 SHALL implement FSM states IDLE, WAIT, ACC, OUT.
REQ-016 In IDLE on edge, SHALL latch din into smp, load cnt<=RD_LAT, and go to WAIT.
REQ-017 In WAIT, SHALL decrement cnt each clock; on the clock where cnt==1, SHALL latch q into dly and go to ACC.
REQ-018 In ACC, SHALL set sum <= sum + smp - (full ? dly : 0), sign-extended to DW+7 bits, then go to OUT.
REQ-019 In OUT, SHALL drive dout_valid=1 for exactly one clock, update dout, then return to IDLE.
REQ-020 The latency from edge-detect clock to dout_valid high SHALL be RD_LAT+2 clocks.
REQ-021 fill counter (7 bits) SHALL increment in ACC while fill<window; full = (fill==window).
REQ-022 While not full, the delayed sample SHALL be treated as 0 (buffer not yet primed).
REQ-023 dout SHALL be sum>>>SHIFT, clamped to [-2^(DW-1), 2^(DW-1)-1].
REQ-024 window==0 SHALL select bypass: ACC sets sum<=smp sign-extended, dout=smp unshifted, and fill is held at 0.
REQ-025 A window change SHALL be detected by comparing against a registered copy; on change, sum and fill SHALL clear at the next IDLE clock, and any in-flight sample SHALL complete with the old accumulation.
REQ-026 An edge arriving in WAIT/ACC/OUT SHALL be ignored and SHALL set overrun; overrun SHALL clear only on reset.
REQ-027 An edge and a window change in the same IDLE clock SHALL clear first, then accept the sample with fill=0.
REQ-028 sum SHALL NOT overflow for |samples| <= 2^(DW-1) and window <= 65 (DW+7 bits suffices).

Reset
REQ-029 While rst_n=0, SHALL hold: state=IDLE, prev_en=0, cnt=0, smp=0, dly=0, sum=0, fill=0, dout=0, dout_valid=0, overrun=0, window copy=0.
REQ-030 Reset asserted mid-operation SHALL abort immediately, with no dout_valid pulse after release until a new edge.
REQ-031 enable held high through reset release SHALL NOT produce an edge until it returns low then high.

Verification
REQ-032 RD_LAT=3, SHIFT=0, window=4, din=10 per edge, q=10: sum SHALL be 10,20,30,40,40,40 and dout_valid SHALL be 5 clocks after each edge.
REQ-033 window=2, din 100 then -100 alternating, q = the value two samples earlier: sum SHALL settle to 0 after priming and saturation SHALL NOT occur.
REQ-034 SHIFT=0, DW=16, window=65, din=q=32767 each edge: sum SHALL reach 2129855 and dout SHALL clamp to 32767.
REQ-035 A second edge 2 clocks after the first SHALL be ignored: overrun=1 and exactly one dout_valid pulse.
REQ-036 window changes 4->0 while full: the next sample SHALL be bypassed, dout=din, sum=din.
REQ-037 rst_n low during WAIT: all outputs SHALL be 0 immediately, and no dout_valid SHALL occur until the next fresh edge.

Source files
------------

// File: rtl/movavg_acc.sv
// Moving-window accumulator: one sample per enable rising edge, delayed sample from buffer RAM
// subtracted once the window is primed, shifted and saturated onto dout.
module movavg_acc #(
    parameter int unsigned DW     = 16,
    parameter int unsigned RD_LAT = 3,
    parameter int unsigned SHIFT  = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [DW-1:0] din,
    input  logic [DW-1:0] q,
    input  logic [6:0]    window,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic [DW+6:0] sum,
    output logic          overrun
);

    localparam int unsigned SW = DW + 7;
    localparam logic signed [SW-1:0] SatMax = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] SatMin = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StWait, StAcc, StOut} state_e;

    state_e               state_q, state_d;
    logic                 prev_en_q;
    logic                 armed_q;
    logic [2:0]           cnt_q;
    logic [DW-1:0]        smp_q;
    logic [DW-1:0]        dly_q;
    logic signed [SW-1:0] sum_q;
    logic [6:0]           fill_q;
    logic [6:0]           win_q;
    logic [DW-1:0]        dout_q;
    logic                 dout_valid_q;
    logic                 overrun_q;

    logic                 en_rise;
    logic                 win_chg;
    logic                 full;
    logic                 bypass;
    logic signed [SW-1:0] smp_ext;
    logic signed [SW-1:0] dly_ext;
    logic signed [SW-1:0] sum_acc;
    logic signed [SW-1:0] sum_shr;
    logic [DW-1:0]        dout_sat;

    // armed_q blocks a false edge when enable is already high as reset releases
    assign en_rise = enable & ~prev_en_q & armed_q;
    assign win_chg = (window != win_q);
    assign full    = (fill_q == win_q);
    assign bypass  = (win_q == 7'd0);

    assign smp_ext = {{7{smp_q[DW-1]}}, smp_q};
    assign dly_ext = {{7{dly_q[DW-1]}}, dly_q};
    assign sum_acc = sum_q + smp_ext - (full ? dly_ext : '0);
    assign sum_shr = sum_q >>> SHIFT;

    always_comb begin
        dout_sat = sum_shr[DW-1:0];
        if (sum_shr > SatMax) begin
            dout_sat = SatMax[DW-1:0];
        end else if (sum_shr < SatMin) begin
            dout_sat = SatMin[DW-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (en_rise) state_d = StWait;
            StWait:  if (cnt_q == 3'd1) state_d = StAcc;
            StAcc:   state_d = StOut;
            StOut:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_en_q    <= 1'b0;
            armed_q      <= 1'b0;
            cnt_q        <= '0;
            smp_q        <= '0;
            dly_q        <= '0;
            sum_q        <= '0;
            fill_q       <= '0;
            win_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            prev_en_q    <= enable;
            dout_valid_q <= 1'b0;
            if (!enable) begin
                armed_q <= 1'b1;
            end
            if (en_rise && (state_q != StIdle)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    // Clear precedes acceptance so a simultaneous edge starts from fill=0
                    if (win_chg) begin
                        sum_q  <= '0;
                        fill_q <= '0;
                        win_q  <= window;
                    end
                    if (en_rise) begin
                        smp_q <= din;
                        cnt_q <= 3'(RD_LAT);
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        dly_q <= q;
                    end
                end
                StAcc: begin
                    if (bypass) begin
                        sum_q <= smp_ext;
                    end else begin
                        sum_q <= sum_acc;
                        if (fill_q < win_q) begin
                            fill_q <= fill_q + 7'd1;
                        end
                    end
                end
                StOut: begin
                    dout_valid_q <= 1'b1;
                    dout_q       <= bypass ? smp_q : dout_sat;
                end
                default: ;
            endcase
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign sum        = sum_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_movavg_acc.sv
// Scoreboard bench for movavg_acc: two instances (SHIFT=0 and SHIFT=6) share stimulus and are
// checked against a window-sum model built from the sample history.
module tb_movavg_acc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] din;
    logic [15:0] q;
    logic [6:0]  window;
    logic [15:0] dout0, dout1;
    logic        dv0, dv1;
    logic [22:0] sum0, sum1;
    logic        ovr0, ovr1;

    always #5 clk = ~clk;

    movavg_acc #(.DW(16), .RD_LAT(3), .SHIFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .din(din), .q(q), .window(window),
        .dout(dout0), .dout_valid(dv0), .sum(sum0), .overrun(ovr0)
    );

    movavg_acc #(.DW(16), .RD_LAT(3), .SHIFT(6)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .din(din), .q(q), .window(window),
        .dout(dout1), .dout_valid(dv1), .sum(sum1), .overrun(ovr1)
    );

    typedef struct {
        int sum;
        int d0;
        int d1;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   hist[$];
    int   w;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   pulses   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Expected result of the next accepted sample; q is what the buffer RAM would return.
    task automatic prep(input int d, input bit fq, input int qf, output exp_t e, output int qv);
        int n;
        int s;
        n = hist.size();
        if (fq) qv = qf;
        else if (w > 0 && n >= w) qv = hist[n-w];
        else qv = int'($urandom_range(0, 65535)) - 32768;
        if (w == 0) begin
            e.sum = d;
            e.d0  = d;
            e.d1  = d;
        end else begin
            hist.push_back(d);
            if (hist.size() > 70) void'(hist.pop_front());
            s = 0;
            for (int i = 0; i < hist.size() && i < w; i++) s += hist[hist.size()-1-i];
            e.sum = s;
            e.d0  = sat(s);
            e.d1  = sat(s >>> 6);
        end
        e.cyc = 0;
    endtask

    task automatic issue(input int d, input int new_w, input int mid_w, input bit fq,
                         input int qf);
        exp_t e;
        int   qv;
        if (new_w != w) begin
            hist.delete();
            w = new_w;
        end
        prep(d, fq, qf, e, qv);
        @(negedge clk);
        window = 7'(new_w);
        din    = 16'(d);
        q      = 16'(qv);
        enable = 1'b1;
        e.cyc  = cyc + 6;
        sb.push_back(e);
        @(negedge clk);
        enable = 1'b0;
        if (mid_w >= 0 && mid_w != w) begin
            window = 7'(mid_w);
            hist.delete();
            w = mid_w;
        end
        repeat (6) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (dv0) pulses++;
            if (dv0 || dv1) begin
                chk("valid_pair", int'(dv1), int'(dv0));
                if (sb.size() == 0) begin
                    chk("unexpected_valid", int'(dv0 | dv1), 0);
                end else begin
                    me = sb.pop_front();
                    chk("latency", cyc, me.cyc);
                    chk("sum0", $signed(sum0), me.sum);
                    chk("sum1", $signed(sum1), me.sum);
                    chk("dout0", $signed(dout0), me.d0);
                    chk("dout1", $signed(dout1), me.d1);
                end
            end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
                chk("missing_valid", int'(dv0), 1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        exp_t e;
        int   qv;
        int   p0;
        int   d;
        int   nw;
        int   mw;

        rst_n  = 1'b0;
        enable = 1'b0;
        din    = '0;
        q      = '0;
        window = 7'd4;
        w      = 4;
        repeat (3) @(negedge clk);
        chk("rst_sum0", int'(sum0), 0);
        chk("rst_sum1", int'(sum1), 0);
        chk("rst_dout0", int'(dout0), 0);
        chk("rst_dout1", int'(dout1), 0);
        chk("rst_valid", int'(dv0 | dv1), 0);
        chk("rst_overrun", int'(ovr0 | ovr1), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Steady input 10 over window 4
        for (int i = 0; i < 6; i++) issue(10, 4, -1, 1'b1, 10);
        chk("win4_final_sum", $signed(sum0), 40);

        // Alternating +-100 over window 2
        for (int i = 0; i < 8; i++) issue((i % 2 == 0) ? 100 : -100, 2, -1, 1'b0, 0);
        chk("alt_final_sum", $signed(sum0), 0);
        chk("alt_final_dout", $signed(dout0), 0);

        // Prime window 4, then switch to bypass
        for (int i = 0; i < 5; i++) issue(int'($urandom_range(0, 400)) - 200, 4, -1, 1'b0, 0);
        issue(777, 0, -1, 1'b0, 0);
        chk("bypass_sum", $signed(sum1), 777);
        chk("bypass_dout1", $signed(dout1), 777);

        // Full-scale samples over the largest window
        for (int i = 0; i < 66; i++) issue(32767, 65, -1, 1'b1, 32767);
        chk("max_sum", $signed(sum0), 2129855);
        chk("max_dout0", $signed(dout0), 32767);
        chk("max_dout1", $signed(dout1), 32767);

        // Second edge while busy
        chk("overrun_before", int'(ovr0 | ovr1), 0);
        p0 = pulses;
        prep(123, 1'b0, 0, e, qv);
        @(negedge clk);
        din    = 16'(123);
        q      = 16'(qv);
        enable = 1'b1;
        e.cyc  = cyc + 6;
        sb.push_back(e);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        din    = 16'h7777;
        @(negedge clk);
        enable = 1'b0;
        repeat (6) @(negedge clk);
        chk("overrun0_set", int'(ovr0), 1);
        chk("overrun1_set", int'(ovr1), 1);
        chk("overrun_pulses", pulses - p0, 1);

        // Randomized traffic with occasional window changes at issue and mid-flight
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 1) == 1) d = int'($urandom_range(0, 65535)) - 32768;
            else d = int'($urandom_range(0, 600)) - 300;
            nw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 65)) : w;
            mw = ($urandom_range(0, 14) == 0) ? int'($urandom_range(1, 65)) : -1;
            issue(d, nw, mw, 1'b0, 0);
        end
        chk("overrun_sticky", int'(ovr0 & ovr1), 1);

        // Reset during WAIT with enable held high across release
        if (w == 0) issue(5, 3, -1, 1'b0, 0);
        prep(55, 1'b0, 0, e, qv);
        @(negedge clk);
        din    = 16'(55);
        q      = 16'(qv);
        enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_sum0", int'(sum0), 0);
        chk("abort_sum1", int'(sum1), 0);
        chk("abort_dout0", int'(dout0), 0);
        chk("abort_dout1", int'(dout1), 0);
        chk("abort_valid", int'(dv0 | dv1), 0);
        chk("abort_overrun", int'(ovr0 | ovr1), 0);
        sb.delete();
        hist.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        p0 = pulses;
        repeat (10) @(negedge clk);
        chk("no_valid_after_reset", pulses - p0, 0);
        enable = 1'b0;
        @(negedge clk);
        issue(-321, w, -1, 1'b0, 0);
        chk("fresh_sum", $signed(sum0), -321);

        repeat (10) @(negedge clk);
        chk("scoreboard_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
